fp64_norm_round: RTL and testbench
==================================

FP64_NORM_ROUND -- requirements
Module: fp64_norm_round

Interface
REQ-001: The block SHALL have the ports below; one clock `clk` and one reset `rst_n`, asynchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_sign  in  1  product sign (sign_a XOR sign_b)
- in_exp  in  13  signed two's-complement biased exponent sum, exp_a + exp_b - 1023, computed without truncation
- in_mant  in  106  raw 53x53 mantissa product (hidden bits included)
- in_zero  in  1  an operand is zero
- in_inf  in  1  an operand is infinity
- in_nan  in  1  an operand is NaN
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_result  out  64  IEEE-754 double result
- out_ovf  out  1  overflow flag
- out_unf  out  1  underflow (flush) flag
- out_inexact  out  1  result inexact

Function
REQ-002: The block SHALL be a 2-stage pipeline: S1 (normalize), then S2 (round/pack); S2's registers drive the outputs.
REQ-003: Latency SHALL be 2 cycles: a beat accepted at edge N appears at edge N+2 when out_ready=1 throughout.
REQ-004: A beat SHALL transfer on an input edge when in_valid & in_ready, and on an output edge when out_valid & out_ready.
REQ-005: S2 SHALL load from S1 when S2 is empty or out_ready=1; in_ready SHALL be (S1 empty) OR (S1 will advance).
REQ-006: Throughput SHALL be 1 beat per cycle with no bubbles while out_ready=1.
REQ-007: With out_ready=0 and out_valid=1, out_result and the flags SHALL hold stable; no beat is lost or duplicated.
REQ-008: S1 normalization when in_mant[105]=1: fraction = in_mant[104:53], guard = in_mant[52], sticky = |in_mant[51:0], exponent = in_exp+1.
REQ-009: S1 normalization when in_mant[105]=0: fraction = in_mant[103:52], guard = in_mant[51], sticky = |in_mant[50:0], exponent = in_exp.
REQ-010: S2 SHALL round to nearest, ties to even: increment when guard & (sticky | fraction[0]).
REQ-011: If the increment carries out of the fraction, the fraction SHALL become 0 and the exponent SHALL increase by 1.
REQ-012: out_inexact SHALL equal guard | sticky for finite, in-range results.
REQ-013: If the final exponent is >= 2047, the result SHALL be sign, 0x7FF, fraction 0 (infinity), with out_ovf=1 and out_inexact=1.
REQ-014: If the final exponent is <= 0, the result SHALL be signed zero, with out_unf=1 and out_inexact=1; subnormals are not produced.
REQ-015: Special cases SHALL take this priority: in_nan, or (in_inf & in_zero), gives 0x7FF8000000000000 with no flags.
REQ-016: Otherwise in_inf SHALL give signed infinity with no flags.
REQ-017: Otherwise in_zero SHALL give signed zero with no flags.
REQ-018: All exponent arithmetic SHALL be 13-bit signed; the packed exponent field is the low 11 bits of an in-range result.

Reset
REQ-019: While rst_n=0, out_valid=0, in_ready=0, out_result=0, and out_ovf, out_unf and out_inexact are all 0.
REQ-020: Pipeline valid bits SHALL clear immediately on reset assertion.
REQ-021: Beats in flight when reset asserts SHALL be discarded and never emitted.
REQ-022: in_ready SHALL go to 1 on the first clock edge after rst_n deasserts.

Verification
REQ-023: 1.0x1.0: in_exp=1023, in_mant=2^104, sign=0 -> out_result=0x3FF0000000000000 two cycles later; all flags 0.
REQ-024: 1.5x1.5: in_exp=1023, in_mant=0x9*2^102, sign=1 -> 0xC002000000000000; flags 0.
REQ-025: Round carry: in_exp=1023, in_mant[105]=0, in_mant[104:52] all ones, in_mant[51]=1 -> 0x4000000000000000 with inexact=1.
REQ-026: Range limits: in_exp=2047, mant=2^104 -> 0x7FF0000000000000 with ovf=1; in_exp=0, mant=2^104, sign=1 -> 0x8000000000000000 with unf=1.
REQ-027: Specials: in_inf=1 and in_zero=1 -> 0x7FF8000000000000.
REQ-028: Backpressure: stream 5 beats, hold out_ready=0 for 4 cycles mid-stream -> all 5 results in order, stable while stalled, and in_ready=0 while both stages are full.
REQ-029: Reset mid-stream: assert rst_n=0 with 2 beats in flight -> out_valid=0 at once; after release, a new beat emerges correctly and no stale beat appears.

Source files
------------

// File: rtl/fp64_norm_round.sv
// -----------------------------------------------------------------------------
// fp64_norm_round
//
// Back end of an IEEE-754 double-precision multiplier. It takes the raw
// 53x53 mantissa product and the biased exponent sum, then normalizes,
// rounds (nearest, ties to even) and packs the double. Specials are resolved
// from the operand class flags. Subnormal results are flushed to zero.
//
// Pipeline: S1 (normalize) -> S2 (round/pack). S2 registers drive every
// output, so results are stable for as long as out_ready holds them.
// Valid/ready handshake on both sides. Latency is 2 cycles and throughput is
// one beat per cycle.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     input beat valid
//   in_ready     block can accept a beat
//   in_sign      product sign
//   in_exp       13-bit signed biased exponent sum (exp_a + exp_b - 1023)
//   in_mant      106-bit raw mantissa product, hidden bits included
//   in_zero      an operand is zero
//   in_inf       an operand is infinity
//   in_nan       an operand is NaN
//   out_valid    result valid
//   out_ready    downstream accepts result
//   out_result   IEEE-754 double result
//   out_ovf      overflow (result forced to infinity)
//   out_unf      underflow (result flushed to signed zero)
//   out_inexact  result inexact
// -----------------------------------------------------------------------------
module fp64_norm_round (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_sign,
    input  logic [12:0]  in_exp,
    input  logic [105:0] in_mant,
    input  logic         in_zero,
    input  logic         in_inf,
    input  logic         in_nan,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_result,
    output logic         out_ovf,
    output logic         out_unf,
    output logic         out_inexact
);

    localparam logic [63:0] QNAN_C     = 64'h7FF8_0000_0000_0000;
    localparam logic [10:0] EXP_MAX_C  = 11'h7FF;

    // -------------------------------------------------------------------------
    // Handshake control
    // -------------------------------------------------------------------------
    // ready_en_q keeps in_ready low during reset and raises it on the first
    // edge after release.
    logic ready_en_q;
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s2_load_s;
    logic in_ready_s;
    logic in_fire_s;

    // Handshake decode: S2 takes a new beat whenever it is empty or draining;
    // S1 can accept whenever it is empty or moving into S2 this cycle.
    always_comb begin
        s2_load_s  = (~s2_valid_q) | out_ready;
        in_ready_s = ready_en_q & ((~s1_valid_q) | s2_load_s);
        in_fire_s  = in_valid & in_ready_s;
    end

    assign in_ready = in_ready_s;

    // Next-state for the two stage valid bits.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        if (in_fire_s) begin
            s1_valid_d = 1'b1;
        end else if (s2_load_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (s2_load_s) begin
            s2_valid_d = s1_valid_q;
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Control registers; reset discards any beat in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
        end
    end

    // -------------------------------------------------------------------------
    // S1: normalize
    // -------------------------------------------------------------------------
    // The product of two 1.x mantissas lies in [1,4), so it is either already
    // normalized at bit 104 or needs a one-place right shift from bit 105.
    logic [51:0] s1_frac_d,   s1_frac_q;
    logic        s1_guard_d,  s1_guard_q;
    logic        s1_sticky_d, s1_sticky_q;
    logic [12:0] s1_exp_d,    s1_exp_q;
    logic        s1_sign_q;
    logic        s1_nan_q;
    logic        s1_inf_q;
    logic        s1_zero_q;

    // Normalization shift and guard/sticky extraction.
    always_comb begin
        s1_frac_d   = 52'd0;
        s1_guard_d  = 1'b0;
        s1_sticky_d = 1'b0;
        s1_exp_d    = 13'd0;
        if (in_mant[105]) begin
            s1_frac_d   = in_mant[104:53];
            s1_guard_d  = in_mant[52];
            s1_sticky_d = |in_mant[51:0];
            s1_exp_d    = in_exp + 13'd1;
        end else begin
            s1_frac_d   = in_mant[103:52];
            s1_guard_d  = in_mant[51];
            s1_sticky_d = |in_mant[50:0];
            s1_exp_d    = in_exp;
        end
    end

    // S1 data registers; captured only on an accepted input beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_frac_q   <= 52'd0;
            s1_guard_q  <= 1'b0;
            s1_sticky_q <= 1'b0;
            s1_exp_q    <= 13'd0;
            s1_sign_q   <= 1'b0;
            s1_nan_q    <= 1'b0;
            s1_inf_q    <= 1'b0;
            s1_zero_q   <= 1'b0;
        end else if (in_fire_s) begin
            s1_frac_q   <= s1_frac_d;
            s1_guard_q  <= s1_guard_d;
            s1_sticky_q <= s1_sticky_d;
            s1_exp_q    <= s1_exp_d;
            s1_sign_q   <= in_sign;
            // inf x 0 is invalid and folds into the NaN class here.
            s1_nan_q    <= in_nan | (in_inf & in_zero);
            s1_inf_q    <= in_inf;
            s1_zero_q   <= in_zero;
        end else begin
            s1_frac_q   <= s1_frac_q;
            s1_guard_q  <= s1_guard_q;
            s1_sticky_q <= s1_sticky_q;
            s1_exp_q    <= s1_exp_q;
            s1_sign_q   <= s1_sign_q;
            s1_nan_q    <= s1_nan_q;
            s1_inf_q    <= s1_inf_q;
            s1_zero_q   <= s1_zero_q;
        end
    end

    // -------------------------------------------------------------------------
    // S2: round and pack
    // -------------------------------------------------------------------------
    logic               rnd_inc_s;
    logic [52:0]        frac_sum_s;
    logic [51:0]        frac_rnd_s;
    logic signed [12:0] exp_rnd_s;
    logic [63:0]        result_d;
    logic               ovf_d;
    logic               unf_d;
    logic               inexact_d;

    // Round to nearest even. A carry out of the fraction leaves the stored
    // fraction bits at zero and bumps the exponent.
    always_comb begin
        rnd_inc_s  = s1_guard_q & (s1_sticky_q | s1_frac_q[0]);
        frac_sum_s = {1'b0, s1_frac_q} + {52'd0, rnd_inc_s};
        frac_rnd_s = frac_sum_s[51:0];
        if (frac_sum_s[52]) begin
            exp_rnd_s = $signed(s1_exp_q + 13'd1);
        end else begin
            exp_rnd_s = $signed(s1_exp_q);
        end
    end

    // Result selection: specials first, then range limits, then normal pack.
    always_comb begin
        result_d  = 64'd0;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        inexact_d = 1'b0;
        if (s1_nan_q) begin
            result_d = QNAN_C;
        end else if (s1_inf_q) begin
            result_d = {s1_sign_q, EXP_MAX_C, 52'd0};
        end else if (s1_zero_q) begin
            result_d = {s1_sign_q, 63'd0};
        end else if (exp_rnd_s >= 13'sd2047) begin
            result_d  = {s1_sign_q, EXP_MAX_C, 52'd0};
            ovf_d     = 1'b1;
            inexact_d = 1'b1;
        end else if (exp_rnd_s <= 13'sd0) begin
            result_d  = {s1_sign_q, 63'd0};
            unf_d     = 1'b1;
            inexact_d = 1'b1;
        end else begin
            result_d  = {s1_sign_q, exp_rnd_s[10:0], frac_rnd_s};
            inexact_d = s1_guard_q | s1_sticky_q;
        end
    end

    logic [63:0] s2_result_q;
    logic        s2_ovf_q;
    logic        s2_unf_q;
    logic        s2_inexact_q;

    // Output registers; they hold while the downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_result_q  <= 64'd0;
            s2_ovf_q     <= 1'b0;
            s2_unf_q     <= 1'b0;
            s2_inexact_q <= 1'b0;
        end else if (s2_load_s && s1_valid_q) begin
            s2_result_q  <= result_d;
            s2_ovf_q     <= ovf_d;
            s2_unf_q     <= unf_d;
            s2_inexact_q <= inexact_d;
        end else begin
            s2_result_q  <= s2_result_q;
            s2_ovf_q     <= s2_ovf_q;
            s2_unf_q     <= s2_unf_q;
            s2_inexact_q <= s2_inexact_q;
        end
    end

    assign out_valid   = s2_valid_q;
    assign out_result  = s2_result_q;
    assign out_ovf     = s2_ovf_q;
    assign out_unf     = s2_unf_q;
    assign out_inexact = s2_inexact_q;

endmodule

// File: tb/tb_fp64_norm_round.sv
// -----------------------------------------------------------------------------
// tb_fp64_norm_round
//
// Directed bench for fp64_norm_round. A table of hand-computed vectors is fed
// through the input handshake; each accepted beat pushes its expected
// {ovf, unf, inexact, result} onto a queue that an output monitor drains in
// order. Additional directed checks cover reset values, latency, stream
// throughput, backpressure stability and reset in mid-stream.
// -----------------------------------------------------------------------------
module tb_fp64_norm_round;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_sign;
    logic [12:0]  in_exp;
    logic [105:0] in_mant;
    logic         in_zero;
    logic         in_inf;
    logic         in_nan;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_result;
    logic         out_ovf;
    logic         out_unf;
    logic         out_inexact;

    fp64_norm_round dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sign     (in_sign),
        .in_exp      (in_exp),
        .in_mant     (in_mant),
        .in_zero     (in_zero),
        .in_inf      (in_inf),
        .in_nan      (in_nan),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_ovf     (out_ovf),
        .out_unf     (out_unf),
        .out_inexact (out_inexact)
    );

    // Clock generation, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic         sign;
        logic [12:0]  exp;
        logic [105:0] mant;
        logic [2:0]   spec;   // {nan, inf, zero}
        logic [66:0]  expv;   // {ovf, unf, inexact, result}
    } vec_t;

    vec_t        vecs [0:17];
    int          nvec;
    logic [66:0] exp_q [$];
    int          checks;
    int          errors;
    int          cyc;
    int          acc_cnt;
    int          emit_cnt;
    logic [66:0] held_v;
    logic        held_ok;

    // Single comparison point for the whole bench.
    task automatic check_val(input string tag, input logic [66:0] obs, input logic [66:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic add_vec(input logic s, input logic [12:0] e, input logic [105:0] m,
                           input logic [2:0] sp, input logic [66:0] ev);
        vecs[nvec] = {s, e, m, sp, ev};
        nvec++;
    endtask

    // Present one vector and wait (bounded) for it to be accepted.
    task automatic send(input int idx);
        bit done;
        int budget;
        in_sign  = vecs[idx].sign;
        in_exp   = vecs[idx].exp;
        in_mant  = vecs[idx].mant;
        in_nan   = vecs[idx].spec[2];
        in_inf   = vecs[idx].spec[1];
        in_zero  = vecs[idx].spec[0];
        in_valid = 1'b1;
        done     = 1'b0;
        budget   = 0;
        while (!done && budget < 50) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(vecs[idx].expv);
                acc_cnt++;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            budget++;
        end
        if (!done) check_val("accept_timeout", 67'd1, 67'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Cycle counter for throughput measurement.
    always @(posedge clk) cyc++;

    // Output monitor: compares each transferring beat and checks stall stability.
    initial begin
        held_ok = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() > 0) begin
                    check_val("result", {out_ovf, out_unf, out_inexact, out_result}, exp_q.pop_front());
                end else begin
                    check_val("extra_beat", 67'd1, 67'd0);
                end
                emit_cnt++;
            end
            if (rst_n && out_valid && !out_ready) begin
                if (held_ok) check_val("stall_hold", {out_ovf, out_unf, out_inexact, out_result}, held_v);
                held_v  = {out_ovf, out_unf, out_inexact, out_result};
                held_ok = 1'b1;
            end else begin
                held_ok = 1'b0;
            end
        end
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    logic [105:0] ones54;
    int           t0;
    int           base;

    initial begin
        checks = 0; errors = 0; cyc = 0; acc_cnt = 0; emit_cnt = 0; nvec = 0;
        ones54 = ((106'd1 << 54) - 106'd1) << 51;

        add_vec(1'b0, 13'd1023, 106'd1 << 104,                             3'b000, {3'b000, 64'h3FF0_0000_0000_0000});
        add_vec(1'b1, 13'd1023, 106'd9 << 102,                             3'b000, {3'b000, 64'hC002_0000_0000_0000});
        add_vec(1'b0, 13'd1023, ones54,                                    3'b000, {3'b001, 64'h4000_0000_0000_0000});
        add_vec(1'b0, 13'd2047, 106'd1 << 104,                             3'b000, {3'b101, 64'h7FF0_0000_0000_0000});
        add_vec(1'b1, 13'd0,    106'd1 << 104,                             3'b000, {3'b011, 64'h8000_0000_0000_0000});
        add_vec(1'b0, 13'd1023, 106'd1 << 104,                             3'b011, {3'b000, 64'h7FF8_0000_0000_0000});
        add_vec(1'b1, 13'd1023, 106'd1 << 104,                             3'b100, {3'b000, 64'h7FF8_0000_0000_0000});
        add_vec(1'b1, 13'd1023, 106'd1 << 104,                             3'b010, {3'b000, 64'hFFF0_0000_0000_0000});
        add_vec(1'b1, 13'd1023, 106'd1 << 104,                             3'b001, {3'b000, 64'h8000_0000_0000_0000});
        add_vec(1'b0, 13'd1023, (106'd1 << 104) | (106'd1 << 51),          3'b000, {3'b001, 64'h3FF0_0000_0000_0000});
        add_vec(1'b0, 13'd1023, (106'd1 << 104) | (106'd3 << 51),          3'b000, {3'b001, 64'h3FF0_0000_0000_0002});
        add_vec(1'b0, 13'd1023, (106'd1 << 104) | (106'd1 << 51) | 106'd1, 3'b000, {3'b001, 64'h3FF0_0000_0000_0001});
        add_vec(1'b0, 13'd1023, (106'd1 << 104) | 106'd1,                  3'b000, {3'b001, 64'h3FF0_0000_0000_0000});
        add_vec(1'b0, 13'd1023, (106'd1 << 105) | (106'd1 << 52),          3'b000, {3'b001, 64'h4000_0000_0000_0000});
        add_vec(1'b0, 13'd2046, ones54,                                    3'b000, {3'b101, 64'h7FF0_0000_0000_0000});
        add_vec(1'b0, 13'd0,    106'd1 << 105,                             3'b000, {3'b000, 64'h0010_0000_0000_0000});
        add_vec(1'b0, 13'h1FFB, 106'd1 << 104,                             3'b000, {3'b011, 64'h0000_0000_0000_0000});
        add_vec(1'b0, 13'd2046, 106'd1 << 104,                             3'b000, {3'b000, 64'h7FE0_0000_0000_0000});

        // Reset state.
        rst_n = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        in_sign = 1'b0; in_exp = 13'd0; in_mant = 106'd0;
        in_zero = 1'b0; in_inf = 1'b0; in_nan = 1'b0;
        idle(3);
        @(negedge clk);
        check_val("rst_out_valid", {66'd0, out_valid}, 67'd0);
        check_val("rst_in_ready",  {66'd0, in_ready},  67'd0);
        check_val("rst_result",    {3'b000, out_result}, 67'd0);
        check_val("rst_flags",     {64'd0, out_ovf, out_unf, out_inexact}, 67'd0);
        rst_n = 1'b1;
        #1;
        check_val("ready_pre_edge", {66'd0, in_ready}, 67'd0);
        @(posedge clk);
        #1;
        check_val("ready_post_edge", {66'd0, in_ready}, 67'd1);

        // Latency: accepted at edge N, valid after N+1, transfers at N+2.
        send(0);
        in_valid = 1'b0;
        check_val("lat_n", {66'd0, out_valid}, 67'd0);
        @(posedge clk);
        #1;
        check_val("lat_n1", {66'd0, out_valid}, 67'd1);
        idle(4);

        // Full table, back to back: one acceptance per cycle.
        t0 = cyc;
        for (int i = 0; i < nvec; i++) send(i);
        in_valid = 1'b0;
        check_val("throughput", 67'(cyc - t0), 67'(nvec));
        idle(6);

        // Backpressure: 5 beats, out_ready low for 4 cycles mid-stream.
        base = acc_cnt;
        fork
            begin
                send(1); send(2); send(10); send(11); send(8);
                in_valid = 1'b0;
            end
            begin
                wait (acc_cnt >= base + 2);
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check_val("stall_in_ready", {66'd0, in_ready}, 67'd0);
                    check_val("stall_out_valid", {66'd0, out_valid}, 67'd1);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        idle(8);
        check_val("bp_drained", 67'(exp_q.size()), 67'd0);

        // Reset with two beats in flight.
        send(1); send(2);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid",  {66'd0, out_valid}, 67'd0);
        check_val("mid_rst_ready",  {66'd0, in_ready},  67'd0);
        check_val("mid_rst_result", {3'b000, out_result}, 67'd0);
        exp_q.delete();
        emit_cnt = 0;
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(17);
        in_valid = 1'b0;
        idle(6);
        check_val("post_rst_count", 67'(emit_cnt), 67'd1);
        check_val("final_queue", 67'(exp_q.size()), 67'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
